// File: rtl/apexii_ddio_tx_pkg.sv
// Shared types and helpers for the DDIO TX burst controller.
// The TRAIN state exists only when DDIO_TX_TRAIN_EN is defined.
package apexii_ddio_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        DATA  = 3'd2,
        POST  = 3'd3
`ifdef DDIO_TX_TRAIN_EN
        ,
        TRAIN = 3'd4
`endif
    } state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        int w = 1;
        while ((2 ** w) <= max_val) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/apexii_ddio_tx_dncnt.sv
// Loadable down-counter with zero flag.
// One instance times PRE, POST, starvation gap and training.
import apexii_ddio_tx_pkg::*;

module apexii_ddio_tx_dncnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt_q;

    // Load wins over decrement; decrement stops at zero.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/apexii_ddio_tx_burst_ctrl.sv
// Burst sequencer feeding a DDIO bidir output cell.
// Optional training sequence: define DDIO_TX_TRAIN_EN.
import apexii_ddio_tx_pkg::*;

module apexii_ddio_tx_burst_ctrl #(
    parameter int W           = 8,
    parameter int PRE_CYCLES  = 2,
    parameter int POST_CYCLES = 1,
    parameter int GAP_MAX     = 4,
    parameter int TRAIN_LEN   = 8
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] in_data,
    input  logic           in_last,
    output logic [W-1:0]   datain_h,
    output logic [W-1:0]   datain_l,
    output logic           oe,
    output logic           clkena,
    output logic           busy,
    output logic           underrun
`ifdef DDIO_TX_TRAIN_EN
    ,
    input  logic           train_req,
    output logic           train_done
`endif
);

    localparam int M1 = (PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES;
    localparam int M2 = (GAP_MAX > TRAIN_LEN) ? GAP_MAX : TRAIN_LEN;
    localparam int CW = cnt_width((M1 > M2) ? M1 : M2);

    localparam logic [CW-1:0] PRE_LD  = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] POST_LD = CW'(POST_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_MAX - 1);
`ifdef DDIO_TX_TRAIN_EN
    localparam logic [CW-1:0] TRN_LD  = CW'(TRAIN_LEN - 1);
`endif

    state_t          state_q, state_d;
    logic [2*W-1:0]  hold_q;
    logic            hold_last_q;
    logic            hold_en;
    logic            fire;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]   cnt_val;
    logic [W-1:0]    h_d, l_d;
    logic            oe_d, und_d;
    logic            train_blk;
`ifdef DDIO_TX_TRAIN_EN
    logic            done_d;
    assign train_blk = train_req;
`else
    assign train_blk = 1'b0;
`endif

    assign in_ready = ((state_q == IDLE) && !train_blk) || (state_q == DATA);
    assign fire     = in_valid && in_ready;

    apexii_ddio_tx_dncnt #(.CW(CW)) u_cnt (
        .clk      (clk),
        .areset   (areset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    // Next state, counter control and next registered pad values.
    always_comb begin
        state_d  = state_q;
        h_d      = '0;
        l_d      = '0;
        oe_d     = 1'b1;
        und_d    = 1'b0;
        hold_en  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
`ifdef DDIO_TX_TRAIN_EN
        done_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                oe_d = 1'b0;
`ifdef DDIO_TX_TRAIN_EN
                if (train_req) begin
                    state_d  = TRAIN;
                    oe_d     = 1'b1;
                    h_d      = '1;
                    cnt_load = 1'b1;
                    cnt_val  = TRN_LD;
                end else
`endif
                if (fire) begin
                    state_d  = PRE;
                    oe_d     = 1'b1;
                    hold_en  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = PRE_LD;
                end
            end
            PRE: begin
                if (cnt_zero) begin
                    h_d      = hold_q[W-1:0];
                    l_d      = hold_q[2*W-1:W];
                    cnt_load = 1'b1;
                    state_d  = hold_last_q ? POST : DATA;
                    cnt_val  = hold_last_q ? POST_LD : GAP_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DATA: begin
                if (fire) begin
                    h_d      = in_data[W-1:0];
                    l_d      = in_data[2*W-1:W];
                    cnt_load = 1'b1;
                    state_d  = in_last ? POST : DATA;
                    cnt_val  = in_last ? POST_LD : GAP_LD;
                end else begin
                    und_d = 1'b1;
                    if (cnt_zero) begin
                        state_d  = POST;
                        cnt_load = 1'b1;
                        cnt_val  = POST_LD;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            POST: begin
                if (cnt_zero) state_d = IDLE;
                else          cnt_dec = 1'b1;
            end
`ifdef DDIO_TX_TRAIN_EN
            TRAIN: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    h_d     = '1;
                    cnt_dec = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
            end
        endcase
    end

    // State and registered pad-side outputs.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            datain_h <= '0;
            datain_l <= '0;
            oe       <= 1'b0;
            clkena   <= 1'b0;
            busy     <= 1'b0;
            underrun <= 1'b0;
`ifdef DDIO_TX_TRAIN_EN
            train_done <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            datain_h <= h_d;
            datain_l <= l_d;
            oe       <= oe_d;
            clkena   <= (state_d != IDLE);
            busy     <= (state_d != IDLE);
            underrun <= und_d;
`ifdef DDIO_TX_TRAIN_EN
            train_done <= done_d;
`endif
        end
    end

    // Capture the word accepted in IDLE until PRE ends.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hold_q      <= '0;
            hold_last_q <= 1'b0;
        end else if (hold_en) begin
            hold_q      <= in_data;
            hold_last_q <= in_last;
        end
    end

endmodule
